// File: rtl/sdram_arbiter.sv
// SDRAM port arbiter: shares one SDRAM controller port between NUM_PORTS
// ROM read clients and the ioctl download writer. ioctl bytes are packed
// into 32-bit words; writes always win over reads, and only one SDRAM
// transaction is ever outstanding. All outputs come straight from registers.
module sdram_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_data,
  output logic                   ioctl_wait,
  input  logic [NUM_PORTS-1:0]   rom_req,
  input  logic [NUM_PORTS*23-1:0] rom_addr,
  output logic [NUM_PORTS-1:0]   rom_ack,
  output logic [NUM_PORTS-1:0]   rom_valid,
  output logic [31:0]            rom_q,
  output logic [22:0]            sdram_addr,
  output logic [31:0]            sdram_data,
  output logic                   sdram_we,
  output logic                   sdram_req,
  input  logic                   sdram_ack,
  input  logic                   sdram_valid,
  input  logic [31:0]            sdram_q
);

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  // Pointer starts at the last port so port 0 is the first one examined.
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ_W,
    S_REQ_R,
    S_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [22:0]          addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [NUM_PORTS-1:0] valid_q, valid_d;
  logic [31:0]          romq_q, romq_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic                 wr_done;

  logic [3:0][7:0]      lane_q, lane_d;
  logic [3:0]           fill_q, fill_d;
  logic [22:0]          asm_addr_q, asm_addr_d;
  logic                 dl_q;
  logic [31:0]          wr_data_q, wr_data_d;
  logic [22:0]          wr_addr_q, wr_addr_d;
  logic                 wr_pending_q, wr_pending_d;

  logic [22:0]          addr_arr [NUM_PORTS];
  logic [GW-1:0]        pick_g;

  // Round-robin: first requesting port at or after last+1 (wrapping).
  // Fixed priority: lowest requesting index.
  function automatic logic [GW-1:0] pick_grant(input logic [NUM_PORTS-1:0] req,
                                               input logic [GW-1:0] last);
    logic [GW-1:0] r;
    logic          found;
    int            idx;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ROUND_ROBIN != 0) idx = (int'(last) + 1 + i) % NUM_PORTS;
      else                  idx = i;
      if (!found && req[idx]) begin
        r     = GW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Unpack the flat client address bus and choose the candidate grant.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) addr_arr[i] = rom_addr[23*i +: 23];
    pick_g = pick_grant(rom_req, last_q);
  end

  // Byte packing, partial-word flush on download end, and write queueing.
  always_comb begin
    lane_d       = lane_q;
    fill_d       = fill_q;
    asm_addr_d   = asm_addr_q;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    wr_pending_d = wr_pending_q;
    if (wr_done) wr_pending_d = 1'b0;
    if (ioctl_wr) begin
      if (ioctl_addr[1:0] == 2'd3) begin
        // A completed word arriving while one is still queued is dropped.
        if (!wr_pending_q) begin
          wr_data_d    = {ioctl_data, lane_q[2], lane_q[1], lane_q[0]};
          wr_addr_d    = ioctl_addr[24:2];
          wr_pending_d = 1'b1;
        end
        lane_d = '0;
        fill_d = '0;
      end else begin
        lane_d[ioctl_addr[1:0]] = ioctl_data;
        fill_d[ioctl_addr[1:0]] = 1'b1;
        asm_addr_d              = ioctl_addr[24:2];
      end
    end else if (dl_q && !ioctl_download && (fill_q != 4'd0)) begin
      // Download ended mid-word: unfilled lanes are already zero.
      if (!wr_pending_q) begin
        wr_data_d    = lane_q;
        wr_addr_d    = asm_addr_q;
        wr_pending_d = 1'b1;
      end
      lane_d = '0;
      fill_d = '0;
    end
  end

  // Packing and write-queue registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q       <= '0;
      fill_q       <= '0;
      asm_addr_q   <= '0;
      dl_q         <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      wr_pending_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      fill_q       <= fill_d;
      asm_addr_q   <= asm_addr_d;
      dl_q         <= ioctl_download;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      wr_pending_q <= wr_pending_d;
    end
  end

  // Transaction FSM: next state and next values of all registered outputs.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = '0;
    valid_d = '0;
    romq_d  = romq_q;
    grant_d = grant_q;
    last_d  = last_q;
    wr_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_pending_q) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = wr_addr_q;
          data_d  = wr_data_q;
          state_d = S_REQ_W;
        end else if (!ioctl_download && (rom_req != '0)) begin
          grant_d = pick_g;
          addr_d  = addr_arr[pick_g];
          req_d   = 1'b1;
          we_d    = 1'b0;
          state_d = S_REQ_R;
        end
      end
      S_REQ_W: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wr_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_REQ_R: begin
        if (sdram_ack) begin
          req_d          = 1'b0;
          ack_d[grant_q] = 1'b1;
          last_d         = grant_q;
          state_d        = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sdram_valid) begin
          romq_d           = sdram_q;
          valid_d[grant_q] = 1'b1;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      valid_q <= '0;
      romq_q  <= '0;
      grant_q <= '0;
      last_q  <= LAST_INIT;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      romq_q  <= romq_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign ioctl_wait = wr_pending_q;
  assign rom_ack    = ack_q;
  assign rom_valid  = valid_q;
  assign rom_q      = romq_q;
  assign sdram_addr = addr_q;
  assign sdram_data = data_q;
  assign sdram_we   = we_q;
  assign sdram_req  = req_q;

endmodule
